// File: rtl/irq_dispatch.sv
// irq_dispatch: interrupt controller (IF/IE/IME, EI delay, HALT wake) and 5-M-cycle dispatch sequencer
// Ports: clk, rst (sync, active-low); irq_in rising edges set IF; if_wr_en/ie_wr_en/wr_data MMIO writes;
//   ei/di/reti retire strobes; boundary = CPU at FETCH; halt_req HALT retire; ack/step CPU handshakes.
//   Outputs: if_q, ie_q, ime, irq_req, irq_vector (valid with jump_pc), push_hi/push_lo/jump_pc strobes,
//   halted, halt_bug.
// Optional: define IRQ_HALT_BUG_EN to pulse halt_bug on HALT with ime==0 and a pending interrupt.
module irq_dispatch #(
  parameter int          N_SRC      = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int          VEC_STRIDE = 8,
  parameter int          EI_DELAY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             if_wr_en,
  input  logic             ie_wr_en,
  input  logic [N_SRC-1:0] wr_data,
  input  logic             ei,
  input  logic             di,
  input  logic             reti,
  input  logic             boundary,
  input  logic             halt_req,
  input  logic             ack,
  input  logic             step,
  output logic [N_SRC-1:0] if_q,
  output logic [N_SRC-1:0] ie_q,
  output logic             ime,
  output logic             irq_req,
  output logic [15:0]      irq_vector,
  output logic             push_hi,
  output logic             push_lo,
  output logic             jump_pc,
  output logic             halted,
  output logic             halt_bug
);
  typedef enum logic [2:0] {IDLE, REQ, D_WAIT1, D_WAIT2, D_PUSHH, D_PUSHL, D_JUMP, HALT} state_t;
  state_t st;
  logic [N_SRC-1:0] prev, pend, rise, clr;
  logic [15:0] idx, vec;
  logic [7:0] cnt;
  logic armed, any, take;
  assign pend = if_q & ie_q;
  assign any = |pend;
  assign rise = irq_in & ~prev;
  assign take = (st == REQ) && ack;
  // lowest set bit wins: scan downwards so the last hit is the lowest index
  always_comb begin
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) idx = pend[i] ? 16'(i) : idx;
  end
  assign vec = VEC_BASE + idx * 16'(VEC_STRIDE);
  assign clr = (take && any) ? (N_SRC'(1) << idx) : '0;
  // hardware edges are OR-ed after the software write so a set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_q <= '0;
      ie_q <= '0;
      prev <= '0;
    end else begin
      if_q <= ((if_wr_en ? wr_data : if_q) | rise) & ~clr;
      ie_q <= ie_wr_en ? wr_data : ie_q;
      prev <= irq_in;
    end
  end
  // di dominates everything; the ack of a dispatch clears ime ahead of reti/ei
  always_ff @(posedge clk) begin
    if (!rst) begin
      ime <= 1'b0;
      armed <= 1'b0;
      cnt <= '0;
    end else if (di) begin
      ime <= 1'b0;
      armed <= 1'b0;
    end else if (take) begin
      ime <= 1'b0;
    end else if (reti) begin
      ime <= 1'b1;
      armed <= 1'b0;
    end else if (ei) begin
      if (EI_DELAY == 0) ime <= 1'b1;
      else begin
        armed <= 1'b1;
        cnt <= 8'(EI_DELAY);
      end
    end else if (armed && boundary) begin
      if (cnt == 8'd1) begin
        ime <= 1'b1;
        armed <= 1'b0;
      end else cnt <= cnt - 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= IDLE;
      irq_req <= 1'b0;
      irq_vector <= '0;
      push_hi <= 1'b0;
      push_lo <= 1'b0;
      jump_pc <= 1'b0;
      halted <= 1'b0;
      halt_bug <= 1'b0;
    end else begin
      push_hi <= 1'b0;
      push_lo <= 1'b0;
      jump_pc <= 1'b0;
      halt_bug <= 1'b0;
      case (st)
        IDLE:
          if (halt_req) begin
            if (!any) begin
              st <= HALT;
              halted <= 1'b1;
            end else if (ime) begin
              st <= REQ;
              irq_req <= 1'b1;
            end
`ifdef IRQ_HALT_BUG_EN
            else halt_bug <= 1'b1;
`else
            else halt_bug <= 1'b0;
`endif
          end else if (ime && any && boundary) begin
            st <= REQ;
            irq_req <= 1'b1;
          end
        REQ:
          if (ack) begin
            irq_req <= 1'b0;
            irq_vector <= any ? vec : 16'h0000;
            st <= D_WAIT1;
          end
        D_WAIT1: st <= step ? D_WAIT2 : D_WAIT1;
        D_WAIT2:
          if (step) begin
            st <= D_PUSHH;
            push_hi <= 1'b1;
          end
        D_PUSHH:
          if (step) begin
            st <= D_PUSHL;
            push_lo <= 1'b1;
          end
        D_PUSHL:
          if (step) begin
            st <= D_JUMP;
            jump_pc <= 1'b1;
          end
        D_JUMP: st <= IDLE;
        HALT:
          if (any) begin
            halted <= 1'b0;
            irq_req <= ime;
            st <= ime ? REQ : IDLE;
          end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_dispatch.sv
// tb_irq_dispatch: directed scenarios plus random stimulus against a behavioural model of irq_dispatch
module tb_irq_dispatch;
`ifdef IRQ_HALT_BUG_EN
  localparam bit BUG = 1'b1;
`else
  localparam bit BUG = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] irq_in = '0, wr_data = '0;
  logic if_wr_en = 0, ie_wr_en = 0, ei = 0, di = 0, reti = 0, boundary = 0, halt_req = 0, ack = 0, step = 0;
  logic [4:0] if_q, ie_q;
  logic ime, irq_req, push_hi, push_lo, jump_pc, halted, halt_bug;
  logic [15:0] irq_vector;
  int vectors = 0, miscompares = 0;
  irq_dispatch dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .if_wr_en(if_wr_en), .ie_wr_en(ie_wr_en), .wr_data(wr_data),
    .ei(ei), .di(di), .reti(reti), .boundary(boundary), .halt_req(halt_req), .ack(ack), .step(step),
    .if_q(if_q), .ie_q(ie_q), .ime(ime), .irq_req(irq_req), .irq_vector(irq_vector), .push_hi(push_hi),
    .push_lo(push_lo), .jump_pc(jump_pc), .halted(halted), .halt_bug(halt_bug)
  );
  always #5 clk = ~clk;
  // model: mode 0 idle, 1 awaiting ack, 2 dispatching (steps counts step pulses), 3 halted
  int mode = 0, steps = 0, ei_left = -1;
  logic [4:0] m_if = '0, m_ie = '0, m_prev = '0;
  logic m_ime = 0, e_ph = 0, e_pl = 0, e_jp = 0, e_hb = 0;
  logic [15:0] m_vec = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return {31'd0, if_q, ie_q, ime, irq_req, irq_vector, push_hi, push_lo, jump_pc, halted, halt_bug};
  endfunction
  function automatic logic [63:0] m_outs();
    return {31'd0, m_if, m_ie, m_ime, mode == 1, m_vec, e_ph, e_pl, e_jp, mode == 3, e_hb};
  endfunction
  task automatic model_step();
    logic [4:0] pend, clr;
    logic took, n_ime;
    if (!rst) begin
      mode = 0; steps = 0; ei_left = -1; m_if = '0; m_ie = '0; m_prev = '0; m_ime = 0; m_vec = '0;
      e_ph = 0; e_pl = 0; e_jp = 0; e_hb = 0;
      return;
    end
    pend = m_if & m_ie; clr = '0; took = 0; n_ime = m_ime;
    e_ph = 0; e_pl = 0; e_jp = 0; e_hb = 0;
    case (mode)
      0: if (halt_req) begin
           if (pend == 0) mode = 3;
           else if (m_ime) mode = 1;
           else e_hb = BUG;
         end else if (m_ime && pend != 0 && boundary) mode = 1;
      1: if (ack) begin
           took = 1; mode = 2; steps = 0; m_vec = 16'h0000;
           for (int i = 0; i < 5; i++)
             if (pend[i] && clr == 0) begin
               clr[i] = 1'b1;
               m_vec = 16'(16'h0040 + i * 8);
             end
         end
      2: if (steps == 4) mode = 0;
         else if (step) begin
           steps++;
           e_ph = steps == 2; e_pl = steps == 3; e_jp = steps == 4;
         end
      default: if (pend != 0) mode = m_ime ? 1 : 0;
    endcase
    if (di) begin n_ime = 0; ei_left = -1; end
    else if (took) n_ime = 0;
    else if (reti) begin n_ime = 1; ei_left = -1; end
    else if (ei) ei_left = 1;
    else if (ei_left > 0 && boundary) begin
      ei_left--;
      if (ei_left == 0) begin n_ime = 1; ei_left = -1; end
    end
    m_if = ((if_wr_en ? wr_data : m_if) | (irq_in & ~m_prev)) & ~clr;
    if (ie_wr_en) m_ie = wr_data;
    m_prev = irq_in;
    m_ime = n_ime;
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("cycle", outs(), m_outs());
    {if_wr_en, ie_wr_en, ei, di, reti, boundary, halt_req, ack, step} = '0;
  endtask
  task automatic wr(input bit to_ie, input logic [4:0] d);
    wr_data = d; if_wr_en = !to_ie; ie_wr_en = to_ie;
    cyc();
  endtask
  logic [4:0] saved;
  initial begin
    cyc(); cyc();
    rst = 1'b1;
    chk("reset_outs", outs(), 64'd0);
    // 1: edge on source 2, dispatch to 0x0050
    ie_wr_en = 1; wr_data = 5'h04; reti = 1; irq_in = 5'h04;
    cyc();
    boundary = 1; cyc();
    chk("t1_req", irq_req, 1);
    ack = 1; cyc();
    chk("t1_ifclr", if_q[2], 0);
    chk("t1_ime", ime, 0);
    step = 1; cyc();
    step = 1; cyc(); chk("t1_pushhi", push_hi, 1);
    step = 1; cyc(); chk("t1_pushlo", push_lo, 1);
    step = 1; cyc(); chk("t1_jump", {jump_pc, irq_vector}, {1'b1, 16'h0050});
    cyc();
    // 2: priority among several pending sources
    wr(1, 5'h1A); wr(0, 5'h1F);
    reti = 1; cyc();
    boundary = 1; cyc();
    ack = 1; cyc();
    chk("t2_vec", irq_vector, 16'h0048);
    chk("t2_if", if_q, 5'h1D);
    repeat (5) begin step = 1; cyc(); end
    // 3: EI delay and ei+di conflict
    wr(1, 5'h00);
    ei = 1; cyc(); chk("t3_ime_early", ime, 0);
    boundary = 1; cyc(); chk("t3_ime_set", ime, 1);
    di = 1; cyc();
    ei = 1; di = 1; cyc();
    boundary = 1; cyc(); boundary = 1; cyc();
    chk("t3_di_wins", ime, 0);
    // 4: HALT entry and wake with ime=0
    wr(0, 5'h00);
    halt_req = 1; cyc(); chk("t4_halted", halted, 1);
    wr(1, 5'h01);
    irq_in = 5'h05; cyc(); chk("t4_still", halted, 1);
    cyc(); chk("t4_wake", {halted, irq_req}, 2'b00);
    // 5: request cancelled by IE write before ack
    reti = 1; cyc();
    boundary = 1; cyc(); chk("t5_req", irq_req, 1);
    wr(1, 5'h00);
    saved = if_q;
    ack = 1; cyc();
    chk("t5_vec", irq_vector, 16'h0000);
    chk("t5_if", if_q, saved);
    repeat (5) begin step = 1; cyc(); end
    // 6: HALT with ime=0 and pending; reset mid-dispatch
    wr(1, 5'h01);
    halt_req = 1; cyc();
    chk("t6_halt_bug", {halt_bug, halted}, {BUG, 1'b0});
    reti = 1; cyc();
    boundary = 1; cyc();
    ack = 1; cyc();
    step = 1; cyc(); step = 1; cyc();
    chk("t6_in_pushh", push_hi, 1);
    rst = 0; cyc(); rst = 1;
    chk("t6_rst", outs(), 64'd0);
    // random phase
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 7) == 0) irq_in = 5'($urandom);
      wr_data = 5'($urandom);
      if_wr_en = $urandom_range(0, 15) == 0;
      ie_wr_en = $urandom_range(0, 7) == 0;
      ei = $urandom_range(0, 11) == 0;
      di = $urandom_range(0, 23) == 0;
      reti = $urandom_range(0, 15) == 0;
      boundary = 1'($urandom);
      halt_req = $urandom_range(0, 15) == 0;
      ack = 1'($urandom);
      step = 1'($urandom);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
